// File: rtl/close_path_pipe.sv
// Three-stage close-path subtractor: |A-B| for exponent difference 0/1, RNE on the guard bit,
// leading-one normalisation, underflow flush. Optional statistics counters via CLOSE_PATH_STATS_EN.
module close_path_pipe #(
  parameter int FRAC_W = 4,
  parameter int EXP_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W-1:0] frac_a,
  input  logic [FRAC_W-1:0] frac_b,
  input  logic [EXP_W-1:0]  exp_large,
  input  logic              sign_large,
  input  logic              one_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W-1:0] frac_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              sign_out,
  output logic              zero_out,
  output logic              uflow_out
`ifdef CLOSE_PATH_STATS_EN
  ,
  output logic [15:0]       stat_zero_cnt,
  output logic [15:0]       stat_uflow_cnt
`endif
);

  localparam int W  = FRAC_W;
  localparam int KW = $clog2(FRAC_W + 1);
  localparam int CW = KW + EXP_W;

  function automatic logic [KW-1:0] lead_one(input logic [W:0] v);
    logic [KW-1:0] pos;
    pos = '0;
    for (int i = 0; i <= W; i++) begin
      if (v[i]) pos = KW'(i);
    end
    return pos;
  endfunction

  // Only the single guard bit is dropped, so ties are exactly guard=1.
  function automatic logic [W-1:0] round_rne(input logic [W:0] m);
    return m[W:1] + {{(W-1){1'b0}}, m[0] & m[1]};
  endfunction

  logic vld_p0, vld_p1, vld_p2;
  logic en_p0, en_p1, en_p2;

  assign en_p2     = ~vld_p2 | out_ready;
  assign en_p1     = ~vld_p1 | en_p2;
  assign en_p0     = ~vld_p0 | en_p1;
  assign in_ready  = en_p0;
  assign out_valid = vld_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (en_p0) vld_p0 <= in_valid;
      if (en_p1) vld_p1 <= vld_p0;
      if (en_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- S1: align, compound subtract, leading-one anticipation ----
  logic        [W:0]    p_s, q_s, r_s;
  logic signed [W+1:0]  d_s;
  logic        [KW-1:0] lop_s;

  always_comb begin
    p_s   = {frac_a, 1'b0};
    q_s   = one_d ? {1'b0, frac_b} : {frac_b, 1'b0};
    d_s   = $signed({1'b0, p_s}) - $signed({1'b0, q_s});
    r_s   = q_s - p_s;
    // For a negative difference ~D = |D|-1, whose leading one may sit one place low.
    lop_s = lead_one(d_s[W+1] ? ~d_s[W:0] : d_s[W:0]);
  end

  logic [W:0]       diff_p0, rev_p0;
  logic             neg_p0, sign_p0;
  logic [KW-1:0]    lop_p0;
  logic [EXP_W-1:0] exp_p0;

  always_ff @(posedge clk) begin
    if (en_p0 && in_valid) begin
      diff_p0 <= d_s[W:0];
      rev_p0  <= r_s;
      neg_p0  <= d_s[W+1];
      lop_p0  <= lop_s;
      exp_p0  <= exp_large;
      sign_p0 <= sign_large;
    end
  end

  // ---- S2: magnitude select, rounding, anticipation correction ----
  logic [W:0]    m_s;
  logic [KW-1:0] k_s, lsh_s, sh_s;
  logic [W-1:0]  frac_pre_s;
  logic          zero_s;

  always_comb begin
    m_s = neg_p0 ? rev_p0 : diff_p0;
    k_s = lop_p0;
    for (int i = 0; i < W; i++) begin
      if (KW'(i) == lop_p0 && m_s[i+1]) k_s = KW'(i + 1);
    end
    zero_s     = (m_s == '0);
    frac_pre_s = (k_s == KW'(W)) ? round_rne(m_s) : m_s[W-1:0];
    lsh_s      = (k_s == KW'(W)) ? '0 : KW'(W - 1) - k_s;
    sh_s       = KW'(W) - k_s;
  end

  logic [W-1:0]     frac_pre_p1;
  logic [KW-1:0]    lsh_p1, sh_p1;
  logic             zero_p1, sign_p1;
  logic [EXP_W-1:0] exp_p1;

  always_ff @(posedge clk) begin
    if (en_p1 && vld_p0) begin
      frac_pre_p1 <= frac_pre_s;
      lsh_p1      <= lsh_s;
      sh_p1       <= sh_s;
      zero_p1     <= zero_s;
      sign_p1     <= sign_p0 ^ neg_p0;
      exp_p1      <= exp_p0;
    end
  end

  // ---- S3: normalising shift, exponent adjust, zero/underflow ----
  logic             uflow_s, flush_s;
  logic [W-1:0]     frac_n;
  logic [EXP_W-1:0] exp_n;

  always_comb begin
    uflow_s = ~zero_p1 & (CW'(sh_p1) >= CW'(exp_p1));
    flush_s = zero_p1 | uflow_s;
    frac_n  = frac_pre_p1 << lsh_p1;
    exp_n   = exp_p1 - EXP_W'(sh_p1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_out  <= '0;
      exp_out   <= '0;
      sign_out  <= 1'b0;
      zero_out  <= 1'b0;
      uflow_out <= 1'b0;
    end else if (en_p2 && vld_p1) begin
      frac_out  <= flush_s ? '0 : frac_n;
      exp_out   <= flush_s ? '0 : exp_n;
      sign_out  <= ~flush_s & sign_p1;
      zero_out  <= flush_s;
      uflow_out <= uflow_s;
    end
  end

`ifdef CLOSE_PATH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_zero_cnt  <= '0;
      stat_uflow_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (zero_out && stat_zero_cnt != 16'hFFFF) stat_zero_cnt <= stat_zero_cnt + 16'd1;
      if (uflow_out && stat_uflow_cnt != 16'hFFFF) stat_uflow_cnt <= stat_uflow_cnt + 16'd1;
    end
  end
`endif

endmodule
